// File: rtl/rr_arb_pkg.sv
// Shared types and widths for the 16-way round-robin arbiter.
package rr_arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arb16_ctrl_dec.sv
// 4-to-16 one-hot decoder with enable; purely combinational, zero latency.
module onehot_dec4
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = en_i;
  end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// 16-way round-robin arbiter with hold limit; gnt follows a non-zero req by 1 cycle.
// No backpressure: the owner leaves on done, on dropping its req, or at the hold limit.
module rr_arb16_ctrl
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   ptr
);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic              hold_max;
  logic              grant_exit;

  // Search starts at ptr and wraps modulo 16 via the natural 4-bit overflow.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign cnt_d      = cnt_q + CNT_W'(1);
  assign hold_max   = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign grant_exit = done | ~req[idx_q] | hold_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_vld) begin
            state_q <= GRANT;
            idx_q   <= pick_idx;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            // Index is cleared so the gap cycle reports no owner.
            state_q <= IDLE;
            ptr_q   <= idx_q + IDX_W'(1);
            idx_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign ptr       = ptr_q;

  onehot_dec4 u_dec (
    .idx_i    (idx_q),
    .en_i     (gnt_valid),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Scoreboard bench for rr_arb16_ctrl: directed scenarios plus randomized traffic.
module tb_rr_arb16_ctrl;

  localparam int MH = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req   = 16'h0;
  logic        done  = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic [3:0]  ptr;

  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic [3:0]  ptr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   run    = 1'b0;

  // Reference: owner number (-1 = none), cycles already served, next search start.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;

  rr_arb16_ctrl #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(logic [15:0] r, logic d);
    exp_t e;
    if (m_owner < 0) begin
      for (int k = 0; k < 16; k++) begin
        int i;
        i = (m_ptr + k) % 16;
        if (m_owner < 0 && r[i]) begin
          m_owner = i;
          m_held  = 1;
        end
      end
    end else if (d || !r[m_owner] || m_held >= MH) begin
      m_ptr   = (m_owner + 1) % 16;
      m_owner = -1;
    end else begin
      m_held++;
    end
    e.gnt = 16'h0;
    if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
    e.idx = (m_owner >= 0) ? 4'(m_owner) : 4'h0;
    e.vld = (m_owner >= 0);
    e.ptr = 4'(m_ptr);
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    sb.delete();
  endtask

  task automatic drive(logic [15:0] r, logic d);
    req  = r;
    done = d;
    model_step(r, d);
  endtask

  task automatic cycle(logic [15:0] r, logic d);
    @(negedge clk);
    drive(r, d);
  endtask

  task automatic release_rst(logic [15:0] r, logic d);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    drive(r, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b0;
    req   = 16'h0;
    done  = 1'b0;
    model_reset();
    release_rst(16'h0, 1'b1);
  endtask

  // Monitor: one expected entry per active edge while running out of reset.
  always @(posedge clk) begin
    #1;
    if (run && rst_n) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("valid_vs_gnt", 32'(gnt_valid), 32'(gnt != 16'h0));
      if (gnt_valid) check("gnt_decode", 32'(gnt), 32'(16'(1) << gnt_idx));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
        check("sb_gnt_idx", 32'(gnt_idx), 32'(mon_e.idx));
        check("sb_gnt_valid", 32'(gnt_valid), 32'(mon_e.vld));
        check("sb_ptr", 32'(ptr), 32'(mon_e.ptr));
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic        d;

    // Reset state before any clock edge.
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_gnt_idx", 32'(gnt_idx), 32'h0);
    check("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    check("rst_ptr", 32'(ptr), 32'h0);
    release_rst(16'h0, 1'b1);

    // Single requester held: 8 grant cycles, one gap, regrant.
    for (int j = 1; j <= 20; j++) begin
      cycle(16'h0001, 1'b0);
      if (j == 9)  check("hold_last_cycle", 32'(gnt), 32'h0001);
      if (j == 10) check("hold_gap_gnt", 32'(gnt), 32'h0);
      if (j == 10) check("hold_gap_ptr", 32'(ptr), 32'h1);
      if (j == 11) check("hold_regrant", 32'(gnt), 32'h0001);
    end

    // All requesting, done after each grant: indices 0..15 then 0.
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      cycle(16'hFFFF, 1'b0);
      cycle(16'hFFFF, 1'b1);
      check("rr_seq_idx", 32'(gnt_idx), 32'(k % 16));
      check("rr_seq_vld", 32'(gnt_valid), 32'h1);
    end

    // Pointer at 15 then wrap to 0.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cycle(16'hFFFF, 1'b0);
      cycle(16'hFFFF, 1'b1);
    end
    cycle(16'h8001, 1'b0);
    check("wrap_ptr15", 32'(ptr), 32'hF);
    cycle(16'h8001, 1'b1);
    check("wrap_gnt15", 32'(gnt), 32'h8000);
    cycle(16'h8001, 1'b0);
    check("wrap_ptr0", 32'(ptr), 32'h0);
    cycle(16'h8001, 1'b1);
    check("wrap_gnt0", 32'(gnt), 32'h0001);
    cycle(16'h0000, 1'b0);
    check("wrap_ptr1", 32'(ptr), 32'h1);

    // Owner 3 drops its request while 5 waits.
    do_reset();
    cycle(16'h0008, 1'b0);
    cycle(16'h0028, 1'b0);
    check("drop_own3", 32'(gnt), 32'h0008);
    cycle(16'h0020, 1'b0);
    check("drop_still3", 32'(gnt), 32'h0008);
    cycle(16'h0020, 1'b0);
    check("drop_gap", 32'(gnt), 32'h0);
    check("drop_ptr", 32'(ptr), 32'h4);
    cycle(16'h0020, 1'b0);
    check("drop_gnt5", 32'(gnt), 32'h0020);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cycle(16'h0002, 1'b0);
    cycle(16'h0002, 1'b1);
    cycle(16'h0001, 1'b0);
    cycle(16'h0001, 1'b0);
    check("pre_arst_gnt", 32'(gnt), 32'h0001);
    check("pre_arst_ptr", 32'(ptr), 32'h2);
    #2;
    run   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_gnt_idx", 32'(gnt_idx), 32'h0);
    check("arst_gnt_valid", 32'(gnt_valid), 32'h0);
    check("arst_ptr", 32'(ptr), 32'h0);
    @(negedge clk);
    release_rst(16'h0010, 1'b0);
    cycle(16'h0010, 1'b0);
    check("post_arst_gnt", 32'(gnt), 32'h0010);
    cycle(16'h0010, 1'b1);
    cycle(16'h0010, 1'b0);
    check("post_arst_ptr", 32'(ptr), 32'h5);

    // Randomized traffic; frequent "keep previous" lets grants reach the hold limit.
    do_reset();
    r = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(7, 0))
        0: r = 16'($urandom);
        1: begin
          r = 16'h0;
          r[$urandom_range(15, 0)] = 1'b1;
          r[$urandom_range(15, 0)] = 1'b1;
        end
        2: r = 16'h0;
        3: r = 16'hFFFF;
        default: r = r;
      endcase
      d = ($urandom_range(5, 0) == 0);
      cycle(r, d);
    end

    cycle(16'h0, 1'b0);
    @(posedge clk);
    #3;
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
